// File: rtl/song_seq_pkg.sv
// Shared definitions for the song sequencer: default sizes and FSM state encoding.
package song_seq_pkg;

   localparam int DEFAULT_NUM_SONGS = 4;
   localparam int DEFAULT_SONG_W    = 2;
   localparam int DEFAULT_DUR_W     = 6;
   localparam int DEFAULT_FETCH_CYC = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_KICK,
      S_FETCH,
      S_TIMING,
      S_END
   } state_t;

endpackage

// File: rtl/song_seq_beat_timer.sv
// Loadable beat down-counter for note durations; zero flags that the note has expired.
module beat_timer
   import song_seq_pkg::*;
#(
   parameter int WIDTH = DEFAULT_DUR_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] value,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // A reload wins over a coincident beat, so that beat is never counted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/song_sequencer.sv
// Song sequencing controller: selection, play/pause and beat-timed note advance.
// Optional macro SONG_SEQ_AUTO_ADVANCE_EN turns end-of-song into continuous playlist playback.
module song_sequencer
   import song_seq_pkg::*;
#(
   parameter int NUM_SONGS = DEFAULT_NUM_SONGS,
   parameter int SONG_W    = DEFAULT_SONG_W,
   parameter int DUR_W     = DEFAULT_DUR_W,
   parameter int FETCH_CYC = DEFAULT_FETCH_CYC
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              play_button,
   input  logic              next_button,
   input  logic              beat,
   input  logic [DUR_W-1:0]  duration,
   input  logic              song_done,
   output logic              play,
   output logic [SONG_W-1:0] song,
   output logic              reader_reset,
   output logic              note_done,
   output logic              note_start,
   output logic              playing
);

   localparam int FW = (FETCH_CYC > 2) ? $clog2(FETCH_CYC) : 1;

   state_t            state, state_nxt;
   logic              play_r, play_r_nxt;
   logic [SONG_W-1:0] song_nxt, song_inc;
   logic [FW-1:0]     fetch_cnt, fetch_cnt_nxt;
   logic              timer_load, timer_en, timer_zero;
   logic              note_done_nxt, note_start_nxt;
   logic              run_state, kick_nxt;

   beat_timer #(.WIDTH(DUR_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (timer_load),
      .en      (timer_en),
      .value   (duration),
      .zero    (timer_zero)
   );

   assign song_inc = (song == SONG_W'(NUM_SONGS - 1)) ? '0 : song + 1'b1;
   assign timer_en = (state == S_TIMING) && play_r && beat;

   // fetch_cnt measures cycles since the note_done pulse; the kick pulse is issued
   // in S_KICK itself, so the count starts at 1 when S_FETCH is entered from there.
   always_comb begin
      state_nxt      = state;
      play_r_nxt     = play_r;
      song_nxt       = song;
      fetch_cnt_nxt  = fetch_cnt;
      timer_load     = 1'b0;
      note_done_nxt  = 1'b0;
      note_start_nxt = 1'b0;

      if (play_button && (state != S_IDLE) && (state != S_END)) begin
         play_r_nxt = !play_r;
      end

      case (state)
         S_IDLE: begin
            if (next_button) begin
               song_nxt = song_inc;
            end
            if (play_button) begin
               play_r_nxt = 1'b1;
               state_nxt  = S_RST;
            end
         end
         S_RST: begin
            state_nxt = S_KICK;
         end
         S_KICK: begin
            if (play_r) begin
               state_nxt     = S_FETCH;
               fetch_cnt_nxt = FW'(1);
            end
         end
         S_FETCH: begin
            if (fetch_cnt == FW'(FETCH_CYC - 1)) begin
               if (song_done) begin
                  state_nxt = S_END;
`ifndef SONG_SEQ_AUTO_ADVANCE_EN
                  if (!next_button) begin
                     play_r_nxt = 1'b0;
                  end
`endif
               end else begin
                  timer_load     = 1'b1;
                  note_start_nxt = 1'b1;
                  state_nxt      = S_TIMING;
               end
            end else begin
               fetch_cnt_nxt = fetch_cnt + 1'b1;
            end
         end
         S_TIMING: begin
            if (play_r && timer_zero) begin
               note_done_nxt = 1'b1;
               fetch_cnt_nxt = '0;
               state_nxt     = S_FETCH;
            end
         end
         S_END: begin
`ifdef SONG_SEQ_AUTO_ADVANCE_EN
            if (play_r) begin
               song_nxt  = song_inc;
               state_nxt = S_RST;
            end
`endif
            if (play_button) begin
               play_r_nxt = 1'b1;
               song_nxt   = song;
               state_nxt  = S_RST;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // A song change abandons whatever note is in flight.
      if (next_button && (state != S_IDLE)) begin
         song_nxt       = song_inc;
         state_nxt      = S_RST;
         timer_load     = 1'b0;
         note_done_nxt  = 1'b0;
         note_start_nxt = 1'b0;
      end
   end

   assign run_state = (state_nxt == S_KICK) || (state_nxt == S_FETCH) || (state_nxt == S_TIMING);
   assign kick_nxt  = (state_nxt == S_KICK) && play_r_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         play_r       <= 1'b0;
         song         <= '0;
         fetch_cnt    <= '0;
         play         <= 1'b0;
         reader_reset <= 1'b0;
         note_done    <= 1'b0;
         note_start   <= 1'b0;
         playing      <= 1'b0;
      end else begin
         state        <= state_nxt;
         play_r       <= play_r_nxt;
         song         <= song_nxt;
         fetch_cnt    <= fetch_cnt_nxt;
         play         <= play_r_nxt && run_state;
         reader_reset <= (state_nxt == S_RST);
         note_done    <= note_done_nxt || kick_nxt;
         note_start   <= note_start_nxt;
         playing      <= play_r_nxt && (state_nxt != S_END);
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: expected pulses are queued with their cycle and song.
module tb_song_sequencer;

   localparam int K_RR = 1;
   localparam int K_ND = 2;
   localparam int K_NS = 3;

   typedef struct {
      int         kind;
      int         at;
      logic [1:0] song;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       play_button, next_button, beat, song_done;
   logic [5:0] duration;
   logic       play, reader_reset, note_done, note_start, playing;
   logic [1:0] song;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t exp_q[$];

   song_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .play_button  (play_button),
      .next_button  (next_button),
      .beat         (beat),
      .duration     (duration),
      .song_done    (song_done),
      .play         (play),
      .song         (song),
      .reader_reset (reader_reset),
      .note_done    (note_done),
      .note_start   (note_start),
      .playing      (playing)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         K_RR:    return "reader_reset";
         K_ND:    return "note_done";
         K_NS:    return "note_start";
         default: return "none";
      endcase
   endfunction

   // Pulses are popped and compared as the DUT presents them.
   always @(negedge clk) begin
      int   k;
      exp_t e;
      while ((exp_q.size() > 0) && (exp_q[0].at < cyc)) begin
         e = exp_q.pop_front();
         n_checks++;
         n_errors++;
         $display("[TB] FAIL missed_%s: no pulse by cycle %0d, required at cycle %0d", kname(e.kind), cyc, e.at);
      end
      k = 0;
      if (reader_reset === 1'b1)    k = K_RR;
      else if (note_done === 1'b1)  k = K_ND;
      else if (note_start === 1'b1) k = K_NS;
      if (k != 0) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("[TB] FAIL stray_%s: got pulse at cycle %0d, required none", kname(k), cyc);
         end else begin
            e = exp_q.pop_front();
            if ((e.kind != k) || (e.at != cyc) || (e.song !== song)) begin
               n_errors++;
               $display("[TB] FAIL pulse_order: got %s at cycle %0d song %0d, required %s at cycle %0d song %0d",
                        kname(k), cyc, song, kname(e.kind), e.at, e.song);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic p, input logic nx);
      play_button = p;
      next_button = nx;
      step(1);
      play_button = 1'b0;
      next_button = 1'b0;
   endtask

   task automatic run_beats(input int n, output int last);
      last = cyc;
      repeat (n) begin
         step(9);
         beat = 1'b1;
         step(1);
         beat = 1'b0;
         last = cyc;
      end
   endtask

   task automatic expect_pulse(input int kind, input int at, input logic [1:0] s);
      exp_t e;
      e.kind = kind;
      e.at   = at;
      e.song = s;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: bench did not finish, required finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int m, c;
      reset_n     = 1'b0;
      play_button = 1'b0;
      next_button = 1'b0;
      beat        = 1'b0;
      song_done   = 1'b0;
      duration    = 6'd3;
      step(2);
      check("rst_play", play, 0);
      check("rst_song", song, 0);
      check("rst_reader_reset", reader_reset, 0);
      check("rst_note_done", note_done, 0);
      check("rst_note_start", note_start, 0);
      check("rst_playing", playing, 0);
      reset_n = 1'b1;
      step(2);

      $display("[TB] song select in idle");
      press(1'b0, 1'b1);
      check("idle_next_1", song, 1);
      press(1'b0, 1'b1);
      check("idle_next_2", song, 2);
      press(1'b0, 1'b1);
      check("idle_next_3", song, 3);
      check("idle_playing", playing, 0);

      $display("[TB] start playback, duration 3");
      press(1'b1, 1'b0);
      m = cyc;
      expect_pulse(K_RR, m, 2'd3);
      expect_pulse(K_ND, m + 1, 2'd3);
      expect_pulse(K_NS, m + 3, 2'd3);
      check("start_playing", playing, 1);
      step(1);
      check("kick_play", play, 1);
      step(2);
      run_beats(3, c);
      expect_pulse(K_ND, c + 1, 2'd3);

      $display("[TB] zero-duration note");
      duration = 6'd0;
      expect_pulse(K_NS, c + 3, 2'd3);
      expect_pulse(K_ND, c + 4, 2'd3);
      expect_pulse(K_NS, c + 6, 2'd3);
      step(4);
      duration = 6'd4;
      step(2);

      $display("[TB] pause mid-note");
      run_beats(1, c);
      press(1'b1, 1'b0);
      check("pause_play", play, 0);
      check("pause_playing", playing, 0);
      run_beats(20, c);
      check("paused_play", play, 0);
      press(1'b1, 1'b0);
      check("resume_play", play, 1);
      run_beats(3, c);
      expect_pulse(K_ND, c + 1, 2'd3);
      expect_pulse(K_NS, c + 3, 2'd3);
      duration = 6'd2;
      step(3);

      $display("[TB] next at song 3 coinciding with expiry");
      run_beats(2, c);
      press(1'b0, 1'b1);
      m = cyc;
      expect_pulse(K_RR, m, 2'd0);
      expect_pulse(K_ND, m + 1, 2'd0);
      expect_pulse(K_NS, m + 3, 2'd0);
      check("wrap_song", song, 0);
      duration = 6'd1;
      step(3);

      $display("[TB] end of song");
      run_beats(1, c);
      expect_pulse(K_ND, c + 1, 2'd0);
      song_done = 1'b1;
      duration  = 6'd3;
`ifdef SONG_SEQ_AUTO_ADVANCE_EN
      expect_pulse(K_RR, c + 4, 2'd1);
      expect_pulse(K_ND, c + 5, 2'd1);
      expect_pulse(K_NS, c + 7, 2'd1);
      step(3);
      check("end_play", play, 0);
      check("end_playing", playing, 0);
      song_done = 1'b0;
      step(1);
      check("auto_song", song, 1);
      check("auto_playing", playing, 1);
      step(3);
`else
      step(3);
      check("end_play", play, 0);
      check("end_playing", playing, 0);
      song_done = 1'b0;
      step(5);
      check("end_hold_play", play, 0);
      check("end_hold_song", song, 0);
      press(1'b1, 1'b0);
      m = cyc;
      expect_pulse(K_RR, m, 2'd0);
      expect_pulse(K_ND, m + 1, 2'd0);
      expect_pulse(K_NS, m + 3, 2'd0);
      check("replay_song", song, 0);
      check("replay_playing", playing, 1);
      step(3);
`endif

      $display("[TB] async reset mid-note");
      step(2);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_play", play, 0);
      check("async_song", song, 0);
      check("async_reader_reset", reader_reset, 0);
      check("async_note_done", note_done, 0);
      check("async_note_start", note_start, 0);
      check("async_playing", playing, 0);
      step(1);
      reset_n = 1'b1;
      step(1);

      $display("[TB] simultaneous play and next");
      press(1'b1, 1'b1);
      m = cyc;
      expect_pulse(K_RR, m, 2'd1);
      expect_pulse(K_ND, m + 1, 2'd1);
      expect_pulse(K_NS, m + 3, 2'd1);
      check("both_idle_song", song, 1);
      step(5);
      press(1'b1, 1'b1);
      m = cyc;
      expect_pulse(K_RR, m, 2'd2);
      check("both_run_song", song, 2);
      check("both_run_playing", playing, 0);
      step(3);
      press(1'b1, 1'b0);
      m = cyc;
      expect_pulse(K_ND, m, 2'd2);
      expect_pulse(K_NS, m + 2, 2'd2);
      step(5);

      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         n_errors++;
         $display("[TB] FAIL pending_%s: not seen, required at cycle %0d", kname(e.kind), e.at);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
